// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types for the decoder control bundle. Defines the
//               control word, the NOP word, ALUOp encodings and the
//               pipeline drain states.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int ALUOP_W = 2;

    localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;  // LW / SW address add
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;  // branch compare
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;  // R/I-type, funct decoded
    localparam logic [ALUOP_W-1:0] ALUOP_JALR   = 2'b11;  // JALR target add

    // Field order is fixed: alu_src is the MSB, halt the LSB (11 bits).
    typedef struct packed {
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic [ALUOP_W-1:0] alu_op;
        logic               branch;
        logic               jalr_sel;
        logic               jal_sel;
        logic               halt;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        PS_RUN    = ST_RUN,
        PS_DRAIN  = ST_DRAIN,
        PS_HALTED = ST_HALTED
    } pipe_state_e;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Load-use hazard compare between the load sitting in EX and
//               the source registers of the instruction in ID. Register 0
//               is hard-wired zero and never creates a dependency.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              load_use
);

    logic rd_nonzero;
    logic src_match;

    // A valid load in EX whose nonzero destination feeds either ID source.
    always_comb begin
        rd_nonzero = |ex_rd;
        src_match  = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        load_use   = ex_valid && ex_mem_read && rd_nonzero && src_match && id_valid;
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Carries the ID-stage control word through EX/MEM/WB with
//               valid bits and destination register. Generates load-use
//               stall, EX-redirect flush and runs the Halt drain FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    output ctrl_t             ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output ctrl_t             mem_ctrl,
    output logic [REG_AW-1:0] mem_rd,
    output ctrl_t             wb_ctrl,
    output logic [REG_AW-1:0] wb_rd,
    output logic              stall,
    output logic              flush,
    output logic              halted
);

    logic              ex_valid_q,  ex_valid_d;
    ctrl_t             ex_ctrl_q,   ex_ctrl_d;
    logic [REG_AW-1:0] ex_rd_q,     ex_rd_d;
    logic              mem_valid_q, mem_valid_d;
    ctrl_t             mem_ctrl_q,  mem_ctrl_d;
    logic [REG_AW-1:0] mem_rd_q,    mem_rd_d;
    logic              wb_valid_q,  wb_valid_d;
    ctrl_t             wb_ctrl_q,   wb_ctrl_d;
    logic [REG_AW-1:0] wb_rd_q,     wb_rd_d;
    pipe_state_e       state_q,     state_d;

    logic load_use;
    logic redirect_eff;
    logic accept;
    logic pipe_empty;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl_q.mem_read),
        .ex_rd       (ex_rd_q),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    // Flush/stall arbitration; flush wins and the FSM stalls while draining.
    always_comb begin
        redirect_eff = ex_redirect && ex_valid_q;
        flush        = redirect_eff;
        stall        = (load_use && !redirect_eff) || (state_q != PS_RUN);
        accept       = id_valid && !stall && !flush && (state_q == PS_RUN);
        pipe_empty   = !(ex_valid_q || mem_valid_q || wb_valid_q);
    end

    // Stage advance: ID->EX only on accept (Halt enters as a bubble), later stages always move.
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_ctrl_d   = CTRL_NOP;
        ex_rd_d     = '0;
        if (accept && !id_ctrl.halt) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = id_ctrl;
            ex_rd_d    = id_rd;
        end
        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = ex_ctrl_q;
        mem_rd_d    = ex_rd_q;
        wb_valid_d  = mem_valid_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_rd_d     = mem_rd_q;
    end

    // Halt drain FSM: HALTED is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PS_RUN:    if (accept && id_ctrl.halt) state_d = PS_DRAIN;
            PS_DRAIN:  if (pipe_empty)             state_d = PS_HALTED;
            PS_HALTED: state_d = PS_HALTED;
            default:   state_d = PS_RUN;
        endcase
    end

    // Pipeline and state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_NOP;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= CTRL_NOP;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= CTRL_NOP;
            wb_rd_q     <= '0;
            state_q     <= PS_RUN;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
            state_q     <= state_d;
        end
    end

    // Stage outputs are forced to NOP when the stage holds no instruction.
    always_comb begin
        ex_ctrl  = ex_valid_q  ? ex_ctrl_q  : CTRL_NOP;
        mem_ctrl = mem_valid_q ? mem_ctrl_q : CTRL_NOP;
        wb_ctrl  = wb_valid_q  ? wb_ctrl_q  : CTRL_NOP;
        ex_rd    = ex_rd_q;
        mem_rd   = mem_rd_q;
        wb_rd    = wb_rd_q;
        halted   = (state_q == PS_HALTED);
    end

endmodule : ctrl_pipe
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Self-checking bench for ctrl_pipe: directed scenarios plus
//               random traffic against a three-slot behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          id_valid;
    ctrl_t         id_ctrl;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          ex_redirect;
    ctrl_t         ex_ctrl, mem_ctrl, wb_ctrl;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;
    logic          stall, flush, halted;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_ctrl     (id_ctrl),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .ex_redirect (ex_redirect),
        .ex_ctrl     (ex_ctrl),
        .ex_rd       (ex_rd),
        .mem_ctrl    (mem_ctrl),
        .mem_rd      (mem_rd),
        .wb_ctrl     (wb_ctrl),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .flush       (flush),
        .halted      (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: slot 0 = EX, 1 = MEM, 2 = WB; mode 0 running, 1 draining, 2 halted.
    typedef struct packed {
        logic          v;
        ctrl_t         c;
        logic [AW-1:0] rd;
    } slot_t;
    slot_t pipe_m [3];
    int    mode_m;

    ctrl_t r_type, lw, halt_c;

    function automatic logic [15:0] cz(input ctrl_t c);
        return {5'b0, c};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe_m[i] = '0;
        mode_m = 0;
    endtask

    task automatic drive(input logic v, input ctrl_t c, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic [AW-1:0] d, input logic redir);
        id_valid    = v;
        id_ctrl     = c;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = d;
        ex_redirect = redir;
    endtask

    task automatic idle();
        drive(1'b0, CTRL_NOP, '0, '0, '0, 1'b0);
    endtask

    // Check every output against the model, then advance one clock (starts/ends at negedge).
    task automatic step();
        logic  hz, fl, st, take;
        slot_t nxt;
        int    mode_n;
        #1;
        fl = ex_redirect && pipe_m[0].v;
        hz = id_valid && pipe_m[0].v && pipe_m[0].c.mem_read && (pipe_m[0].rd != 0)
             && (pipe_m[0].rd == id_rs1 || pipe_m[0].rd == id_rs2);
        st = (hz && !fl) || (mode_m != 0);
        take = id_valid && !st && !fl && (mode_m == 0);
        chk("ex_ctrl",  cz(ex_ctrl),  pipe_m[0].v ? cz(pipe_m[0].c) : 16'd0);
        chk("ex_rd",    16'(ex_rd),   16'(pipe_m[0].rd));
        chk("mem_ctrl", cz(mem_ctrl), pipe_m[1].v ? cz(pipe_m[1].c) : 16'd0);
        chk("mem_rd",   16'(mem_rd),  16'(pipe_m[1].rd));
        chk("wb_ctrl",  cz(wb_ctrl),  pipe_m[2].v ? cz(pipe_m[2].c) : 16'd0);
        chk("wb_rd",    16'(wb_rd),   16'(pipe_m[2].rd));
        chk("stall",    16'(stall),   16'(st));
        chk("flush",    16'(flush),   16'(fl));
        chk("halted",   16'(halted),  16'(mode_m == 2));
        mode_n = mode_m;
        if (mode_m == 1 && !(pipe_m[0].v || pipe_m[1].v || pipe_m[2].v)) mode_n = 2;
        else if (take && id_ctrl.halt) mode_n = 1;
        nxt = (take && !id_ctrl.halt) ? {1'b1, id_ctrl, id_rd} : '0;
        @(posedge clk);
        pipe_m[2] = pipe_m[1];
        pipe_m[1] = pipe_m[0];
        pipe_m[0] = nxt;
        mode_m    = mode_n;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ex"},  cz(ex_ctrl) | 16'(ex_rd),   16'd0);
        chk({tag, "_mem"}, cz(mem_ctrl) | 16'(mem_rd), 16'd0);
        chk({tag, "_wb"},  cz(wb_ctrl) | 16'(wb_rd),   16'd0);
        chk({tag, "_sfh"}, {13'd0, stall, flush, halted}, 16'd0);
    endtask

    initial begin
        logic [10:0] rb;
        ctrl_t       rc;

        r_type = CTRL_NOP; r_type.reg_write = 1'b1; r_type.alu_op = ALUOP_RTYPE;
        lw = CTRL_NOP; lw.alu_src = 1'b1; lw.mem_to_reg = 1'b1; lw.reg_write = 1'b1;
        lw.mem_read = 1'b1; lw.alu_op = ALUOP_MEM;
        halt_c = CTRL_NOP; halt_c.halt = 1'b1;

        // Reset state
        reset_n = 1'b0;
        idle();
        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: R-type rd=5 flows EX -> MEM -> WB
        drive(1'b1, r_type, 5'd1, 5'd2, 5'd5, 1'b0);
        step();
        idle(); #1;
        chk("t1_ex_rw", 16'(ex_ctrl.reg_write), 16'd1);
        chk("t1_ex_rd", 16'(ex_rd), 16'd5);
        step(); #1;
        chk("t1_mem_rd", 16'(mem_rd), 16'd5);
        step(); #1;
        chk("t1_wb_rd", 16'(wb_rd), 16'd5);
        chk("t1_wb_rw", 16'(wb_ctrl.reg_write), 16'd1);
        step();

        // 2: LW rd=3 then dependent ADD -> one stall cycle
        drive(1'b1, lw, 5'd0, 5'd0, 5'd3, 1'b0);
        step();
        drive(1'b1, r_type, 5'd3, 5'd4, 5'd6, 1'b0); #1;
        chk("t2_stall", 16'(stall), 16'd1);
        step(); #1;
        chk("t2_bubble", cz(ex_ctrl), 16'd0);
        chk("t2_stall_clr", 16'(stall), 16'd0);
        step();
        idle(); #1;
        chk("t2_add_ex_rd", 16'(ex_rd), 16'd6);
        step();

        // 3: load to x0 never hazards
        drive(1'b1, lw, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b1, r_type, 5'd0, 5'd0, 5'd7, 1'b0); #1;
        chk("t3_no_stall", 16'(stall), 16'd0);
        step();
        idle(); #1;
        chk("t3_ex_rd", 16'(ex_rd), 16'd7);
        step();

        // 4: load-use together with redirect -> flush wins
        drive(1'b1, lw, 5'd0, 5'd0, 5'd3, 1'b0);
        step();
        drive(1'b1, r_type, 5'd3, 5'd0, 5'd8, 1'b1); #1;
        chk("t4_flush", 16'(flush), 16'd1);
        chk("t4_stall", 16'(stall), 16'd0);
        step();
        idle(); #1;
        chk("t4_ex_bubble", cz(ex_ctrl) | 16'(ex_rd), 16'd0);
        chk("t4_mem_rd", 16'(mem_rd), 16'd3);
        step();

        // Random traffic, Halt excluded, small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rb = 11'($urandom_range(0, 2047));
            rc = rb;
            rc.halt = 1'b0;
            drive($urandom_range(0, 3) != 0, rc, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0);
            step();
        end
        idle();
        step(); step(); step();

        // 5: three ADDs then Halt; drain and halt
        drive(1'b1, r_type, 5'd0, 5'd0, 5'd1, 1'b0); step();
        drive(1'b1, r_type, 5'd0, 5'd0, 5'd2, 1'b0); step();
        drive(1'b1, r_type, 5'd0, 5'd0, 5'd3, 1'b0); step();
        drive(1'b1, halt_c, 5'd0, 5'd0, 5'd0, 1'b0); step();
        drive(1'b1, r_type, 5'd0, 5'd0, 5'd9, 1'b0); #1;
        chk("t5_stall_drain", 16'(stall), 16'd1);
        chk("t5_ex_bubble", cz(ex_ctrl), 16'd0);
        step(); step(); #1;
        chk("t5_empty", cz(ex_ctrl) | cz(mem_ctrl) | cz(wb_ctrl), 16'd0);
        chk("t5_not_yet", 16'(halted), 16'd0);
        step(); #1;
        chk("t5_halted", 16'(halted), 16'd1);
        chk("t5_stall_hold", 16'(stall), 16'd1);
        step(); step(); #1;
        chk("t5_ignored", cz(ex_ctrl) | 16'(ex_rd), 16'd0);
        chk("t5_sticky", 16'(halted), 16'd1);

        // Recover from HALTED
        reset_n = 1'b0; #1;
        model_reset();
        chk_all_zero("t5_rst");
        @(negedge clk);
        reset_n = 1'b1;

        // 6: reset pulsed while draining
        drive(1'b1, r_type, 5'd0, 5'd0, 5'd4, 1'b0); step();
        drive(1'b1, halt_c, 5'd0, 5'd0, 5'd0, 1'b0); step();
        idle(); #1;
        chk("t6_drain_mem", cz(mem_ctrl), cz(r_type));
        chk("t6_drain_stall", 16'(stall), 16'd1);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("t6_async");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, r_type, 5'd1, 5'd1, 5'd10, 1'b0); #1;
        chk("t6_run_stall", 16'(stall), 16'd0);
        step();
        idle(); #1;
        chk("t6_ex_rd", 16'(ex_rd), 16'd10);
        step(); step(); #1;
        chk("t6_wb_rd", 16'(wb_rd), 16'd10);
        chk("t6_wb_rw", 16'(wb_ctrl.reg_write), 16'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ctrl_pipe
`default_nettype wire
